// File: rtl/assembler_pkg.sv
// Shared types and ASCII constants for the assembler front end.
package assembler_pkg;

   typedef enum logic [2:0] {
      LINE_START,
      TOKEN,
      LINE_REST,
      COMMENT,
      EMIT,
      DONE
   } state_t;

   typedef enum logic {
      INSTR = 1'b0,
      LABEL = 1'b1
   } map_kind_t;

   localparam logic [7:0] NL    = 8'h0A;
   localparam logic [7:0] CR    = 8'h0D;
   localparam logic [7:0] TAB   = 8'h09;
   localparam logic [7:0] SPACE = 8'h20;
   localparam logic [7:0] HASH  = 8'h23;
   localparam logic [7:0] COLON = 8'h3A;

endpackage

// File: rtl/ascii_class.sv
// Combinational character classifier shared by the mapper and the tokenizer.
module ascii_class
   import assembler_pkg::*;
(
   input  logic [7:0] char_in,
   output logic       ws,
   output logic       nl,
   output logic       id,
   output logic       digit,
   output logic       hash,
   output logic       colon,
   output logic       other
);

   always_comb begin
      ws    = (char_in == SPACE) || (char_in == TAB) || (char_in == CR);
      nl    = (char_in == NL);
      id    = ((char_in >= 8'h61) && (char_in <= 8'h7A)) ||
              ((char_in >= 8'h41) && (char_in <= 8'h5A)) ||
              (char_in == 8'h5F) || (char_in == 8'h2E);
      digit = (char_in >= 8'h30) && (char_in <= 8'h39);
      hash  = (char_in == HASH);
      colon = (char_in == COLON);
      other = !(ws || nl || id || digit || hash || colon);
   end

endmodule

// File: rtl/pc_line_mapper.sv
// Streaming first-pass mapper: classifies source lines and emits {line, pc, kind}
// records for instructions and labels over a valid/ready port.
module pc_line_mapper
   import assembler_pkg::*;
#(
   parameter  int NUMBER_LINES = 256,
   parameter  int PC_STEP      = 4,
   localparam int PC_WIDTH     = $clog2(NUMBER_LINES * PC_STEP),
   localparam int LINE_WIDTH   = $clog2(NUMBER_LINES) + 1,
   localparam int CNT_WIDTH    = PC_WIDTH - $clog2(PC_STEP) + 1
)(
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  char_valid_in,
   input  logic [7:0]            char_in,
   output logic                  char_ready_out,
   input  logic                  end_in,
   output logic                  map_valid_out,
   input  logic                  map_ready_in,
   output logic [LINE_WIDTH-1:0] map_line_out,
   output logic [PC_WIDTH-1:0]   map_pc_out,
   output logic                  map_kind_out,
   output logic [CNT_WIDTH-1:0]  instr_count_out,
   output logic                  done_out,
   output logic                  overflow_out
);

   localparam logic [PC_WIDTH-1:0]   PC_INC   = PC_WIDTH'(PC_STEP);
   localparam logic [PC_WIDTH-1:0]   PC_MAX   = PC_WIDTH'((NUMBER_LINES - 1) * PC_STEP);
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = CNT_WIDTH'(NUMBER_LINES);
   localparam logic [LINE_WIDTH-1:0] LINE_MAX = '1;

   state_t                state, ret_state, nxt_state, ret_nxt;
   map_kind_t             rec_kind, ld_kind;
   logic [PC_WIDTH-1:0]   pc, rec_pc;
   logic [LINE_WIDTH-1:0] line, rec_line;
   logic [CNT_WIDTH-1:0]  instr_count;
   logic                  overflow;
   logic                  load, line_inc, drop;
   logic                  c_ws, c_nl, c_id, c_digit, c_hash, c_colon, c_other;

   ascii_class u_class (
      .char_in (char_in),
      .ws      (c_ws),
      .nl      (c_nl),
      .id      (c_id),
      .digit   (c_digit),
      .hash    (c_hash),
      .colon   (c_colon),
      .other   (c_other)
   );

   assign char_ready_out  = (state != EMIT) && (state != DONE);
   assign map_valid_out   = (state == EMIT);
   assign done_out        = (state == DONE);
   assign map_line_out    = rec_line;
   assign map_pc_out      = rec_pc;
   assign map_kind_out    = rec_kind;
   assign instr_count_out = instr_count;
   assign overflow_out    = overflow;

   // Decode the accepted char first, then fold end_in on top of its outcome.
   always_comb begin
      nxt_state = state;
      ret_nxt   = LINE_START;
      ld_kind   = INSTR;
      load      = 1'b0;
      line_inc  = 1'b0;
      if (char_ready_out && char_valid_in) begin
         case (state)
            LINE_START: begin
               if (c_nl)                    line_inc  = 1'b1;
               else if (c_hash)             nxt_state = COMMENT;
               else if (c_id)               nxt_state = TOKEN;
               else if (c_other || c_digit) nxt_state = LINE_REST;
            end
            TOKEN: begin
               if (c_colon) begin
                  load    = 1'b1;
                  ld_kind = LABEL;
               end else if (c_ws) begin
                  load    = 1'b1;
                  ret_nxt = LINE_REST;
               end else if (c_nl) begin
                  load     = 1'b1;
                  line_inc = 1'b1;
               end else if (c_hash) begin
                  load    = 1'b1;
                  ret_nxt = COMMENT;
               end else if (c_other) begin
                  load    = 1'b1;
                  ret_nxt = LINE_REST;
               end
            end
            LINE_REST, COMMENT: begin
               if (c_nl) begin
                  line_inc  = 1'b1;
                  nxt_state = LINE_START;
               end
            end
            default: ;
         endcase
      end
      if (char_ready_out && end_in) begin
         if (load) begin
            ret_nxt = DONE;
         end else if (nxt_state == TOKEN) begin
            load    = 1'b1;
            ld_kind = INSTR;
            ret_nxt = DONE;
         end else begin
            nxt_state = DONE;
         end
      end
   end

   assign drop = load && (ld_kind == INSTR) && (instr_count == CNT_MAX);

   // pc saturates at the last mapped slot so labels after overflow stay in range.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state       <= LINE_START;
         ret_state   <= LINE_START;
         pc          <= '0;
         line        <= '0;
         instr_count <= '0;
         overflow    <= 1'b0;
         rec_line    <= '0;
         rec_pc      <= '0;
         rec_kind    <= INSTR;
      end else if (state == EMIT) begin
         if (map_ready_in) begin
            state <= ret_state;
            if (rec_kind == INSTR) begin
               instr_count <= instr_count + 1'b1;
               if (pc != PC_MAX) pc <= pc + PC_INC;
            end
         end
      end else if (state != DONE) begin
         if (line_inc && (line != LINE_MAX)) line <= line + 1'b1;
         if (drop) begin
            overflow <= 1'b1;
            state    <= ret_nxt;
         end else if (load) begin
            state     <= EMIT;
            ret_state <= ret_nxt;
            rec_line  <= line;
            rec_pc    <= pc;
            rec_kind  <= ld_kind;
         end else begin
            state <= nxt_state;
         end
      end
   end

endmodule

// File: tb/tb_pc_line_mapper.sv
// Scoreboard bench for pc_line_mapper: default build plus a tiny build for overflow.
module tb_pc_line_mapper;

   typedef struct {
      int line;
      int pc;
      bit kind;
   } rec_t;

   logic       clk = 0;
   logic       rst_n = 1;
   logic       mr = 1;
   logic       cv = 0, ce = 0, cv_s = 0, ce_s = 0;
   logic [7:0] cd = 0, cd_s = 0;

   logic       cr, mv, mk, dn, ov;
   logic [8:0] ml, ic;
   logic [9:0] mp;
   logic       cr_s, mv_s, mk_s, dn_s, ov_s;
   logic [1:0] ml_s, mp_s, ic_s;

   rec_t q[$];
   rec_t qs[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pc_line_mapper dut (
      .clk_in(clk), .rst_in(rst_n), .char_valid_in(cv), .char_in(cd),
      .char_ready_out(cr), .end_in(ce), .map_valid_out(mv), .map_ready_in(mr),
      .map_line_out(ml), .map_pc_out(mp), .map_kind_out(mk),
      .instr_count_out(ic), .done_out(dn), .overflow_out(ov)
   );

   pc_line_mapper #(.NUMBER_LINES(2), .PC_STEP(2)) dut_s (
      .clk_in(clk), .rst_in(rst_n), .char_valid_in(cv_s), .char_in(cd_s),
      .char_ready_out(cr_s), .end_in(ce_s), .map_valid_out(mv_s), .map_ready_in(mr),
      .map_line_out(ml_s), .map_pc_out(mp_s), .map_kind_out(mk_s),
      .instr_count_out(ic_s), .done_out(dn_s), .overflow_out(ov_s)
   );

   task automatic check(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitors: pop and compare on every accepted record.
   always @(negedge clk) begin
      if (rst_n && mv && mr) begin
         check("rec_expected", q.size() > 0, 1);
         if (q.size() > 0) begin
            rec_t r;
            r = q.pop_front();
            check("rec_line", ml, r.line);
            check("rec_pc", mp, r.pc);
            check("rec_kind", mk, r.kind);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && mv_s && mr) begin
         check("s_rec_expected", qs.size() > 0, 1);
         if (qs.size() > 0) begin
            rec_t r;
            r = qs.pop_front();
            check("s_rec_line", ml_s, r.line);
            check("s_rec_pc", mp_s, r.pc);
            check("s_rec_kind", mk_s, r.kind);
         end
      end
   end

   task automatic send(input bit s, input byte c, input bit e, input bit v);
      int n = 0;
      @(negedge clk);
      while (!(s ? cr_s : cr) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!(s ? cr_s : cr)) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: char_ready stuck at 0 (t=%0t)", $time);
         return;
      end
      if (s) begin cv_s = v; cd_s = c; ce_s = e; end
      else   begin cv = v;   cd = c;   ce = e;   end
      @(posedge clk);
      #1;
      cv = 0; ce = 0; cv_s = 0; ce_s = 0;
   endtask

   task automatic send_str(input bit s, input string str);
      for (int i = 0; i < str.len(); i++) send(s, str[i], 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #2 rst_n = 0;
      idle(2);
      check("rst_char_ready", cr, 1);
      check("rst_map_valid", mv, 0);
      check("rst_done", dn, 0);
      check("rst_overflow", ov, 0);
      check("rst_instr_count", ic, 0);
      check("rst_map_pc", mp, 0);
      rst_n = 1;

      // Two plain instructions.
      q.push_back('{0, 0, 0});
      q.push_back('{1, 4, 0});
      send_str(0, "add x1\nsub x2\n");
      idle(4);
      check("t1_instr_count", ic, 2);

      // Label, blank line, comment.
      do_reset();
      q.push_back('{0, 0, 1});
      q.push_back('{0, 0, 0});
      q.push_back('{3, 4, 0});
      send_str(0, "loop: addi x1\n\n# c\nj loop\n");
      idle(4);
      check("t2_instr_count", ic, 2);

      // Backpressure on the first record.
      do_reset();
      mr = 0;
      q.push_back('{0, 0, 0});
      q.push_back('{1, 4, 0});
      send_str(0, "add ");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_char_ready", cr, 0);
         check("bp_valid", mv, 1);
         check("bp_line", ml, 0);
         check("bp_pc", mp, 0);
         check("bp_kind", mk, 0);
      end
      mr = 1;
      send_str(0, "x1\nsub\n");
      idle(4);
      check("t3_instr_count", ic, 2);

      // Flush on end_in without trailing newline.
      do_reset();
      q.push_back('{0, 0, 0});
      send_str(0, "nop");
      send(0, 8'h00, 1'b1, 1'b0);
      idle(4);
      check("t4_done", dn, 1);
      check("t4_char_ready", cr, 0);
      check("t4_instr_count", ic, 1);

      // Colon and end_in in the same cycle: label first, then done.
      do_reset();
      q.push_back('{0, 0, 1});
      send(0, "x", 1'b0, 1'b1);
      send(0, ":", 1'b1, 1'b1);
      idle(4);
      check("t5_done", dn, 1);
      check("t5_instr_count", ic, 0);

      // Reset while a record is pending.
      do_reset();
      q.push_back('{0, 0, 0});
      send_str(0, "a\n");
      idle(3);
      mr = 0;
      send_str(0, "add ");
      @(negedge clk);
      check("t6_valid_before_rst", mv, 1);
      #2 rst_n = 0;
      #1;
      check("t6_valid_async_drop", mv, 0);
      check("t6_char_ready_rst", cr, 1);
      @(negedge clk);
      rst_n = 1;
      mr = 1;
      check("t6_instr_count_rst", ic, 0);
      q.push_back('{0, 0, 0});
      send_str(0, "or\n");
      idle(4);
      check("t6_instr_count", ic, 1);

      // Overflow on the small build.
      qs.push_back('{0, 0, 0});
      qs.push_back('{1, 2, 0});
      send_str(1, "a\nb\nc\n");
      idle(4);
      check("ovf_flag", ov_s, 1);
      check("ovf_instr_count", ic_s, 2);
      check("ovf_no_record", mv_s, 0);

      check("q_drained", q.size(), 0);
      check("qs_drained", qs.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not complete (t=%0t)", $time);
      $fatal(1);
   end

endmodule
